// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit capture register between N_REQ requesters.
// Each transaction grants for one cycle, captures the winner's slice, then holds it for HOLD_CYCLES.
module dff_share_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*WIDTH-1:0]     i_din,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [WIDTH-1:0]           o_q,
    output logic                       o_q_valid,
    output logic [$clog2(N_REQ)-1:0]   o_q_owner
);

    localparam int OWN_W = $clog2(N_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [WIDTH-1:0]   r_q;
    logic               r_q_valid;
    logic [OWN_W-1:0]   r_q_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic [OWN_W-1:0]   r_last;
    logic [OWN_W-1:0]   r_win;

    state_t             w_state_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_q_valid_nxt;
    logic [OWN_W-1:0]   w_q_owner_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [OWN_W-1:0]   w_last_nxt;
    logic [OWN_W-1:0]   w_win_nxt;

    logic [OWN_W-1:0]   w_idx;
    logic [OWN_W-1:0]   w_rr_win;
    logic               w_rr_found;

    // Walk upward from the slot after the last owner, wrapping, and keep the first active request.
    always_comb begin
        w_idx      = r_last;
        w_rr_win   = '0;
        w_rr_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + OWN_W'(1);
            if (!w_rr_found && i_req[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = '0;
        w_q_nxt       = r_q;
        w_q_valid_nxt = r_q_valid;
        w_q_owner_nxt = r_q_owner;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        w_win_nxt     = r_win;
        unique case (r_state)
            S_IDLE: begin
                if (w_rr_found) begin
                    w_gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_rr_win;
                    w_win_nxt   = w_rr_win;
                    w_state_nxt = S_CAPT;
                end
            end
            // DIN is taken here, not at arbitration, so the winner may update it during its grant.
            S_CAPT: begin
                w_q_nxt       = i_din[r_win*WIDTH +: WIDTH];
                w_q_owner_nxt = r_win;
                w_last_nxt    = r_win;
                w_q_valid_nxt = 1'b1;
                w_cnt_nxt     = CNT_LOAD;
                w_state_nxt   = S_HOLD;
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_q_valid_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Reset leaves the pointer on the top slot so requester 0 wins first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_q_owner <= '0;
            r_cnt     <= '0;
            r_last    <= LAST_IDX;
            r_win     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_q       <= w_q_nxt;
            r_q_valid <= w_q_valid_nxt;
            r_q_owner <= w_q_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_win     <= w_win_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_q       = r_q;
    assign o_q_valid = r_q_valid;
    assign o_q_owner = r_q_owner;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: directed scenarios plus random traffic,
// compared every cycle against a timestamp-based transaction model.
module tb_dff_share_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*WIDTH-1:0]   din;
    logic [N_REQ-1:0]         o_gnt;
    logic [WIDTH-1:0]         o_q;
    logic                     o_q_valid;
    logic [1:0]               o_q_owner;

    always #5 clk = ~clk;

    dff_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_din     (din),
        .o_gnt     (o_gnt),
        .o_q       (o_q),
        .o_q_valid (o_q_valid),
        .o_q_owner (o_q_owner)
    );

    int errors = 0;
    int checks = 0;

    // Model state: transactions are tracked by the edge numbers at which things happen.
    int                edgeNo = 0;
    int                freeAt;
    int                capEdge;
    int                validEnd;
    int                mWinner;
    int                mLast;
    int                grantLog[$];
    logic [N_REQ-1:0]  expGnt;
    logic [WIDTH-1:0]  expQ;
    logic              expValid;
    logic [1:0]        expOwner;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner is the active requester at the smallest forward distance past the last owner.
    function automatic int rrPick(input logic [N_REQ-1:0] r, input int lastIdx);
        int best;
        int bestDist;
        int d;
        best = -1;
        bestDist = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (r[i]) begin
                d = (i - lastIdx - 1 + 2 * N_REQ) % N_REQ;
                if (d < bestDist) begin
                    bestDist = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic modelReset();
        expGnt   = '0;
        expQ     = '0;
        expValid = 1'b0;
        expOwner = '0;
        mLast    = N_REQ - 1;
        mWinner  = 0;
        capEdge  = -1;
        validEnd = -1;
        freeAt   = 0;
    endtask

    task automatic modelEdge();
        edgeNo++;
        if (rst) begin
            modelReset();
            return;
        end
        if (edgeNo == capEdge) begin
            expQ     = din[mWinner*WIDTH +: WIDTH];
            expOwner = 2'(mWinner);
            mLast    = mWinner;
            expValid = 1'b1;
            validEnd = edgeNo + HOLD;
        end else if (edgeNo == validEnd) begin
            expValid = 1'b0;
        end
        expGnt = '0;
        if (edgeNo >= freeAt && req != '0) begin
            mWinner = rrPick(req, mLast);
            expGnt  = N_REQ'(1) << mWinner;
            capEdge = edgeNo + 1;
            freeAt  = edgeNo + 2 + HOLD;
            grantLog.push_back(mWinner);
        end
    endtask

    task automatic compareAll();
        checkOutput("gnt", o_gnt, expGnt);
        checkOutput("q", o_q, expQ);
        checkOutput("q_valid", o_q_valid, expValid);
        checkOutput("q_owner", o_q_owner, expOwner);
    endtask

    task automatic applyStimulus(input logic rstV, input logic [N_REQ-1:0] reqV,
                                 input logic [N_REQ*WIDTH-1:0] dinV);
        @(negedge clk);
        rst = rstV;
        req = reqV;
        din = dinV;
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, '0, '0);
        applyStimulus(1'b1, '0, '0);
        grantLog.delete();
    endtask

    task automatic checkGrants(input string tag, input int expSeq[$]);
        checkOutput({tag, "_count"}, grantLog.size(), expSeq.size());
        for (int i = 0; i < expSeq.size() && i < grantLog.size(); i++)
            checkOutput(tag, grantLog[i], expSeq[i]);
    endtask

    logic [N_REQ-1:0]       rv;
    logic [N_REQ*WIDTH-1:0] dv;
    logic                   rs;

    initial begin
        rst = 1'b1;
        req = '0;
        din = '0;
        modelReset();
        #1;
        compareAll();
        doReset();

        $display("[TB] single request");
        applyStimulus(1'b0, 4'b0100, 32'h00A5_0000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 32'h00A5_0000);
        checkOutput("single_q", o_q, 8'hA5);
        checkOutput("single_owner", o_q_owner, 2);
        checkOutput("single_valid_low", o_q_valid, 0);
        checkGrants("single_grant", '{2});

        $display("[TB] all four held");
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'b1111, 32'h1312_1110);
        checkGrants("all4_order", '{0, 1, 2, 3, 0});

        $display("[TB] fairness");
        doReset();
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 4'b0100 | ((edgeNo + 1 >= freeAt) ? 4'b0001 : 4'b0000), 32'h0);
        checkGrants("fair_order", '{0, 2, 0, 2});

        $display("[TB] request change during hold");
        doReset();
        applyStimulus(1'b0, 4'b0001, 32'h7700_00C1);
        applyStimulus(1'b0, 4'b0001, 32'h7700_00C1);
        applyStimulus(1'b0, 4'b1000, 32'h7700_00C1);
        checkOutput("hold_owner", o_q_owner, 0);
        checkOutput("hold_valid", o_q_valid, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b1000, 32'h7700_00C1);
        checkGrants("hold_next", '{0, 3});

        $display("[TB] reset during hold");
        doReset();
        applyStimulus(1'b0, 4'b0001, 32'h0000_005A);
        applyStimulus(1'b0, 4'b0001, 32'h0000_005A);
        applyStimulus(1'b0, 4'b0000, 32'h0000_005A);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async_gnt", o_gnt, 0);
        checkOutput("async_q", o_q, 0);
        checkOutput("async_valid", o_q_valid, 0);
        checkOutput("async_owner", o_q_owner, 0);
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
        grantLog.delete();
        applyStimulus(1'b0, 4'b0010, 32'h0000_2200);
        checkOutput("post_rst_gnt", o_gnt, 4'b0010);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b0000, 32'h0000_2200);
        checkOutput("post_rst_q", o_q, 8'h22);

        $display("[TB] data change during grant");
        doReset();
        applyStimulus(1'b0, 4'b0010, 32'h0000_3300);
        applyStimulus(1'b0, 4'b0000, 32'h0000_4400);
        checkOutput("late_din_q", o_q, 8'h44);
        checkOutput("late_din_owner", o_q_owner, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0000, 32'h0000_5500);

        $display("[TB] random traffic");
        doReset();
        for (int c = 0; c < 600; c++) begin
            rv = ($urandom_range(0, 3) == 0) ? '0 : N_REQ'($urandom);
            dv = $urandom;
            rs = ($urandom_range(0, 79) == 0);
            applyStimulus(rs, rv, dv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
